scoreboarded_register_file: RTL and testbench

Parametrised multi-port integer register file with a per-register busy scoreboard and a post-reset clear sequencer, for the next-generation pipelined core. It sits between decode/issue and writeback. It provides combinational reads with same-cycle write bypass. It tracks which architectural registers have an in-flight producer, so issue can stall on RAW hazards without a separate scoreboard block. Register 0 is hardwired to zero.

---
 rtl/scoreboarded_register_file.sv | 127 ++++++++++++
 tb/tb_scoreboarded_register_file.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/scoreboarded_register_file.sv
// Multi-port integer register file with write bypass, per-register busy scoreboard
// and a post-reset clear sweep. Register 0 reads as zero and is never busy.
module scoreboarded_register_file #(
    parameter int DataWidth      = 32,
    parameter int RegisterCount  = 32,
    parameter int ReadPortCount  = 2,
    parameter int WritePortCount = 2,
    parameter int ClearOnReset   = 1,
    localparam int AddressWidth  = $clog2(RegisterCount)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    output logic                    ready_o,
    input  logic [AddressWidth-1:0] read_address_i    [ReadPortCount],
    output logic [DataWidth-1:0]    read_data_o       [ReadPortCount],
    output logic                    read_pending_o    [ReadPortCount],
    input  logic                    write_enable_i    [WritePortCount],
    input  logic [AddressWidth-1:0] write_address_i   [WritePortCount],
    input  logic [DataWidth-1:0]    write_data_i      [WritePortCount],
    input  logic                    reserve_valid_i,
    input  logic [AddressWidth-1:0] reserve_address_i
);

    typedef enum logic {
        ST_READY,
        ST_CLEAR
    } state_e;

    localparam logic [AddressWidth-1:0] LastAddr = AddressWidth'(RegisterCount - 1);

    state_e                  r_state;
    state_e                  w_state_next;
    logic [AddressWidth-1:0] r_sweep;
    logic [AddressWidth-1:0] w_sweep_next;
    logic [DataWidth-1:0]    r_regs [RegisterCount];
    logic [RegisterCount-1:0] r_busy;
    logic                    w_active;
    logic [WritePortCount-1:0] w_write_valid;
    logic [ReadPortCount-1:0]  w_read_hit;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= (ClearOnReset != 0) ? ST_CLEAR : ST_READY;
            r_sweep <= AddressWidth'(1);
        end else begin
            r_state <= w_state_next;
            r_sweep <= w_sweep_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_sweep_next = r_sweep;
        if (r_state == ST_CLEAR) begin
            w_sweep_next = r_sweep + 1'b1;
            if (r_sweep == LastAddr) begin
                w_state_next = ST_READY;
            end
        end
    end

    assign w_active = (r_state == ST_READY) && !rst_i;
    assign ready_o  = w_active;

    always_comb begin
        for (int unsigned p = 0; p < WritePortCount; p++) begin
            w_write_valid[p] = write_enable_i[p] && (write_address_i[p] != '0) && w_active;
        end
    end

    // Port loop runs low to high so the highest-indexed port's write lands last.
    always_ff @(posedge clk_i) begin
        r_regs[0] <= '0;
        if (!rst_i) begin
            if (r_state == ST_CLEAR) begin
                r_regs[r_sweep] <= '0;
            end
            for (int unsigned p = 0; p < WritePortCount; p++) begin
                if (w_write_valid[p]) begin
                    r_regs[write_address_i[p]] <= write_data_i[p];
                end
            end
        end
    end

    // Reserve is applied after the write releases so a new producer keeps the bit set.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_busy <= '0;
        end else begin
            for (int unsigned p = 0; p < WritePortCount; p++) begin
                if (w_write_valid[p]) begin
                    r_busy[write_address_i[p]] <= 1'b0;
                end
            end
            if (reserve_valid_i && (reserve_address_i != '0) && (r_state == ST_READY)) begin
                r_busy[reserve_address_i] <= 1'b1;
            end
        end
    end

    always_comb begin
        w_read_hit = '0;
        for (int unsigned r = 0; r < ReadPortCount; r++) begin
            read_data_o[r] = r_regs[read_address_i[r]];
            for (int unsigned p = 0; p < WritePortCount; p++) begin
                if (w_write_valid[p] && (write_address_i[p] == read_address_i[r])) begin
                    read_data_o[r] = write_data_i[p];
                    w_read_hit[r]  = 1'b1;
                end
            end
            read_pending_o[r] = r_busy[read_address_i[r]] && !w_read_hit[r];
            if (!w_active || (read_address_i[r] == '0)) begin
                read_data_o[r]    = '0;
                read_pending_o[r] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (r_regs[0] == '0)
            else $fatal(1, "register x0 holds a non-zero value");
        end
    end

endmodule

// File: tb/tb_scoreboarded_register_file.sv
// Randomised and directed bench for scoreboarded_register_file against an
// array-based reference model of the register/scoreboard rules.
module tb_scoreboarded_register_file;

    localparam int DW = 32;
    localparam int RC = 32;
    localparam int RP = 2;
    localparam int WP = 2;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          ready_o;
    logic [AW-1:0] read_address_i  [RP];
    logic [DW-1:0] read_data_o     [RP];
    logic          read_pending_o  [RP];
    logic          write_enable_i  [WP];
    logic [AW-1:0] write_address_i [WP];
    logic [DW-1:0] write_data_i    [WP];
    logic          reserve_valid_i;
    logic [AW-1:0] reserve_address_i;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] m_mem  [RC];
    bit            m_busy [RC];
    int            m_since;

    always #5 clk = ~clk;

    scoreboarded_register_file #(
        .DataWidth      (DW),
        .RegisterCount  (RC),
        .ReadPortCount  (RP),
        .WritePortCount (WP),
        .ClearOnReset   (1)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .ready_o           (ready_o),
        .read_address_i    (read_address_i),
        .read_data_o       (read_data_o),
        .read_pending_o    (read_pending_o),
        .write_enable_i    (write_enable_i),
        .write_address_i   (write_address_i),
        .write_data_i      (write_data_i),
        .reserve_valid_i   (reserve_valid_i),
        .reserve_address_i (reserve_address_i)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Usable once RC-1 consecutive non-reset cycles have elapsed since reset.
    function automatic bit m_ready();
        return !rst && (m_since >= RC - 1);
    endfunction

    function automatic void model_read(input int a, output logic [31:0] d, output logic p);
        bit hit = 0;
        d = m_mem[a];
        for (int w = 0; w < WP; w++) begin
            if (write_enable_i[w] && write_address_i[w] != 0 && int'(write_address_i[w]) == a) begin
                d   = write_data_i[w];
                hit = 1;
            end
        end
        p = m_busy[a] && !hit;
        if (!m_ready() || a == 0) begin
            d = 0;
            p = 0;
        end
    endfunction

    task automatic settle();
        logic [31:0] d;
        logic        p;
        #4;
        check_eq("ready", 32'(ready_o), 32'(m_ready()));
        for (int r = 0; r < RP; r++) begin
            model_read(int'(read_address_i[r]), d, p);
            check_eq($sformatf("rd%0d_data_x%0d", r, read_address_i[r]), read_data_o[r], d);
            check_eq($sformatf("rd%0d_pend_x%0d", r, read_address_i[r]), 32'(read_pending_o[r]), 32'(p));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_since = 0;
            for (int i = 0; i < RC; i++) begin
                m_busy[i] = 0;
                m_mem[i]  = '0;
            end
        end else begin
            if (m_ready()) begin
                for (int w = 0; w < WP; w++) begin
                    if (write_enable_i[w] && write_address_i[w] != 0) begin
                        m_mem[write_address_i[w]]  = write_data_i[w];
                        m_busy[write_address_i[w]] = 0;
                    end
                end
                if (reserve_valid_i && reserve_address_i != 0) m_busy[reserve_address_i] = 1;
            end
            if (m_since < 1000) m_since++;
        end
        #1;
    endtask

    task automatic idle();
        for (int w = 0; w < WP; w++) begin
            write_enable_i[w]  = 1'b0;
            write_address_i[w] = '0;
            write_data_i[w]    = '0;
        end
        reserve_valid_i   = 1'b0;
        reserve_address_i = '0;
    endtask

    // Called mid-cycle after rst release; counts cycles until ready_o is seen.
    task automatic measure_ready(input string tag);
        int n = 0;
        settle();
        while (!ready_o && n < 64) begin
            tick();
            settle();
            n++;
        end
        check_eq(tag, 32'(n), 32'(RC - 1));
        tick();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        for (int r = 0; r < RP; r++) read_address_i[r] = AW'(r + 1);
        m_since = 0;
        @(posedge clk);
        #1;

        // Reset held two cycles, then clear sweep
        settle(); tick();
        settle(); tick();
        rst = 1'b0;
        measure_ready("clear_latency");
        for (int a = 1; a < RC; a++) begin
            read_address_i[0] = AW'(a);
            read_address_i[1] = AW'(RC - a);
            settle(); tick();
        end

        // Bypass priority
        write_enable_i[0] = 1; write_address_i[0] = 5; write_data_i[0] = 32'hAAAA_0000;
        write_enable_i[1] = 1; write_address_i[1] = 5; write_data_i[1] = 32'h5555_FFFF;
        read_address_i[0] = 5; read_address_i[1] = 0;
        settle();
        check_eq("bypass_prio", read_data_o[0], 32'h5555_FFFF);
        tick();
        idle();
        settle();
        check_eq("bypass_stored", read_data_o[0], 32'h5555_FFFF);
        tick();

        // x0 immunity
        for (int w = 0; w < WP; w++) begin
            write_enable_i[w] = 1; write_address_i[w] = 0; write_data_i[w] = 32'hDEAD_BEEF;
        end
        reserve_valid_i = 1; reserve_address_i = 0;
        read_address_i[0] = 0; read_address_i[1] = 0;
        settle();
        check_eq("x0_data", read_data_o[1], 32'h0);
        tick();
        idle();
        settle();
        check_eq("x0_pend_next", 32'(read_pending_o[0]), 32'h0);
        tick();

        // Scoreboard reserve / release
        read_address_i[0] = 7; read_address_i[1] = 7;
        reserve_valid_i = 1; reserve_address_i = 7;
        settle(); tick();
        idle();
        settle();
        check_eq("x7_pend_rise", 32'(read_pending_o[0]), 32'h1);
        tick();
        settle(); tick();
        write_enable_i[0] = 1; write_address_i[0] = 7; write_data_i[0] = 32'h1234;
        settle();
        check_eq("x7_release_pend", 32'(read_pending_o[1]), 32'h0);
        check_eq("x7_release_data", read_data_o[1], 32'h1234);
        tick();
        idle();
        settle();
        check_eq("x7_after_pend", 32'(read_pending_o[0]), 32'h0);
        tick();

        // Reserve and write collide
        read_address_i[0] = 9;
        reserve_valid_i = 1; reserve_address_i = 9;
        settle(); tick();
        write_enable_i[1] = 1; write_address_i[1] = 9; write_data_i[1] = 32'h42;
        settle(); tick();
        idle();
        settle();
        check_eq("collide_data", read_data_o[0], 32'h42);
        check_eq("collide_pend", 32'(read_pending_o[0]), 32'h1);
        tick();

        // Randomised traffic with hazard-prone small address set and rare resets
        for (int c = 0; c < 2000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int w = 0; w < WP; w++) begin
                write_enable_i[w]  = $urandom_range(0, 1) == 1;
                write_address_i[w] = AW'($urandom_range(0, 7));
                write_data_i[w]    = $urandom;
            end
            reserve_valid_i   = $urandom_range(0, 2) == 0;
            reserve_address_i = AW'($urandom_range(0, 7));
            for (int r = 0; r < RP; r++) read_address_i[r] = AW'($urandom_range(0, 7));
            settle(); tick();
        end
        rst = 1'b0;
        idle();
        for (int n = 0; n < 64 && !ready_o; n++) begin
            settle(); tick();
        end
        settle();
        check_eq("ready_after_random", 32'(ready_o), 32'h1);
        tick();

        // Reset mid-sweep
        write_enable_i[0] = 1; write_address_i[0] = 20; write_data_i[0] = 32'hFFFF_FFFF;
        reserve_valid_i = 1; reserve_address_i = 21;
        settle(); tick();
        idle();
        rst = 1'b1;
        settle(); tick();
        rst = 1'b0;
        for (int n = 0; n < 10; n++) begin
            settle(); tick();
        end
        rst = 1'b1;
        settle(); tick();
        rst = 1'b0;
        read_address_i[0] = 20; read_address_i[1] = 21;
        measure_ready("resweep_latency");
        settle();
        check_eq("x20_cleared", read_data_o[0], 32'h0);
        check_eq("x21_not_busy", 32'(read_pending_o[1]), 32'h0);
        tick();
        for (int a = 0; a < RC; a++) begin
            read_address_i[0] = AW'(a);
            settle(); tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
